avl_mem_responder: RTL and testbench
====================================

Name: avl_mem_responder

Overview:
- Avalon-MM responder (slave) backed by on-chip word memory. It is the target end of the CPU-side memory management unit's Avalon initiator.
- Accepts single-beat reads and writes and returns read data with a fixed, parameterised latency.
- Supports byte enables, a bounded number of outstanding reads and backpressure via avl_wait.
- Used as the simulation and FPGA stand-in for the SDRAM controller until the real controller is integrated.

Parameters:
- ADDR_W, 28, width of avl_addr (word address).
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_AW, 10, log2 of memory depth in words; must be ≤ ADDR_W.
- RD_LAT, 2, cycles from read acceptance to avl_rData_valid; must be ≥ 1.
- MAX_PEND, 2, maximum outstanding reads; must satisfy 1 ≤ MAX_PEND ≤ RD_LAT.

Ports:
- iCLK  in  1  single clock, rising edge.
- iRST_n  in  1  reset, asynchronous, active-low.
- avl_addr  in  ADDR_W  word address.
- avl_read  in  1  read request.
- avl_write  in  1  write request.
- avl_wData  in  DATA_W  write data.
- avl_byteen  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- avl_size  in  1  burst count; 0 and 1 are both treated as one beat.
- avl_wait  out  1  waitrequest; the request is not accepted while high.
- avl_rData_valid  out  1  read data valid, one-cycle pulse per read.
- avl_rData  out  DATA_W  read data.
- err_flag  out  1  sticky protocol/range error.

Behaviour:
- Reset (iRST_n low, asynchronous): avl_rData=0, avl_rData_valid=0, err_flag=0, pending count=0, latency pipe cleared. Memory contents are not reset. avl_wait=1 while iRST_n=0.
- Acceptance: accept = (avl_read | avl_write) & !avl_wait, evaluated at the rising edge. The initiator holds the request until accepted.
- avl_wait: combinational; avl_wait = !iRST_n | (pend_cnt == MAX_PEND). Writes are also stalled while avl_wait=1, so ordering is simple.
- In-range test: address is in range when avl_addr[ADDR_W-1:MEM_AW] == 0.
- Write: on an accepted in-range write, mem[avl_addr[MEM_AW-1:0]] is updated at the same edge, per byte where avl_byteen[i]=1. Zero-latency commit, no response.
- Read: an accepted read samples memory at the acceptance edge into stage 1 of an RD_LAT-deep pipe. avl_rData_valid rises exactly RD_LAT cycles after acceptance and lasts one cycle. avl_rData holds its last value when valid=0.
- Throughput: back-to-back reads return in order, one per cycle.
- Read-after-write, same address, in consecutive accept cycles: returns the new data. A write accepted after a read is issued does not alter that read's data.
- Pending counter:
  - +1 on read accept, -1 on valid output, unchanged when both happen in the same cycle.
  - Never exceeds MAX_PEND; never underflows.
- Simultaneous avl_read & avl_write: the write is performed, the read is dropped (no valid), err_flag is set.
- Out-of-range write: dropped, err_flag set.
- Out-of-range read: still occupies the pipe and returns data 0 with valid, err_flag set.
- err_flag is cleared only by reset.
- Reset mid-operation: in-flight reads are discarded and no valid is produced for them; the first request after reset release is accepted on the first edge with iRST_n=1.
- Pipe structure: a valid bit and a data word per stage; the data register is loaded only when the valid bit is set.

Optional Feature:
- Macro: AVL_WAIT_INJECT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) steps every cycle.
  - avl_wait is additionally forced high when lfsr[1:0]==2'b00, stressing the initiator's hold behaviour.
  - Read latency after acceptance is unchanged.
- Undefined: no LFSR; avl_wait is exactly as specified above.

Decomposition:
- Package avl_pkg:
  - default ADDR_W/DATA_W
  - localparam BE_W = DATA_W/8
  - LFSR seed and taps
  - read-data value for out-of-range access (0)
- Sub-module avl_rd_lat_pipe (params DEPTH, DATA_W):
  - shift register of {valid, data}, async active-low reset on the valid bits only
  - instantiated once for the read return path
- Memory array, byte-enable write logic, pending counter and error logic stay in the top module.

Test Plan:
- Basic write and read: write 0x12345678 to addr 4 with byteen 4'hF, then read addr 4 (RD_LAT=2) → valid exactly 2 cycles after accept, data 0x12345678, err_flag=0.
- Byte enables: write 0xAABBCCDD with byteen 4'b0010 over 0x12345678 → readback 0x1234CC78.
- Backpressure: with MAX_PEND=2, RD_LAT=2, hold avl_read for 4 reads to addr 0..3 → avl_wait high whenever 2 reads are outstanding; all four valids return in address order; count never exceeds 2.
- Protocol error: read and write together to addr 8 with 0xCAFEF00D → memory updated, no valid pulse, err_flag=1 and stays 1 until reset.
- Out-of-range read: addr 1<<MEM_AW → valid after RD_LAT with data 0, err_flag=1.
- Reset mid-read: assert iRST_n=0 one cycle after a read accept → no valid ever produced; after release, a read of addr 4 returns the pre-reset value 0x12345678.

Source files
------------

// File: rtl/avl_pkg.sv
// Shared constants for the Avalon-MM memory responder: default widths, the
// wait-injection LFSR and the data returned for out-of-range reads.
package avl_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [DATA_W_DEF-1:0] OOR_RDATA = '0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avl_rd_lat_pipe.sv
// Fixed-latency read return pipe: DEPTH stages of {valid, data}. Only the
// valid bits and the output data word are reset; inner data words load on valid.
module avl_rd_lat_pipe
  import avl_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // A stage's data word only moves when the word feeding it is valid, so the
  // output word holds the last returned value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q          <= '0;
      dat_q[DEPTH-1] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_d[i]) dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM responder backed by on-chip word memory with fixed read latency.
// Define AVL_WAIT_INJECT_EN to add pseudo-random waitrequest stalls.
module avl_mem_responder
  import avl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_AW   = 10,
  parameter int RD_LAT   = 2,
  parameter int MAX_PEND = 2
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic [ADDR_W-1:0]   avl_addr,
  input  logic                avl_read,
  input  logic                avl_write,
  input  logic [DATA_W-1:0]   avl_wData,
  input  logic [DATA_W/8-1:0] avl_byteen,
  input  logic                avl_size,
  output logic                avl_wait,
  output logic                avl_rData_valid,
  output logic [DATA_W-1:0]   avl_rData,
  output logic                err_flag
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;
  logic              in_range, req_accept, wr_en, rd_issue, inject;
  logic [MEM_AW-1:0] mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic              unused_size;

  // Every request is a single beat, so the burst count carries no information.
  assign unused_size = avl_size;
  assign mem_idx     = avl_addr[MEM_AW-1:0];
  assign in_range    = (avl_addr >> MEM_AW) == '0;

`ifdef AVL_WAIT_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign inject = (lfsr_q[1:0] == 2'b00);
`else
  assign inject = 1'b0;
`endif

  assign avl_wait = !iRST_n | (pend_q == PEND_W'(MAX_PEND)) | inject;

  always_comb begin
    req_accept = (avl_read | avl_write) & ~avl_wait;
    wr_en      = req_accept & avl_write & in_range;
    // A read paired with a write is a protocol error and is dropped.
    rd_issue   = req_accept & avl_read & ~avl_write;
    rd_word    = in_range ? mem[mem_idx] : DATA_W'(OOR_RDATA);
    err_d      = err_q | (req_accept & ((avl_read & avl_write) | ~in_range));
    pend_d     = pend_q;
    case ({rd_issue, avl_rData_valid})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (avl_byteen[i]) mem[mem_idx][8*i +: 8] <= avl_wData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err_flag = err_q;

  avl_rd_lat_pipe #(
    .DEPTH  (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .in_valid  (rd_issue),
    .in_data   (rd_word),
    .out_valid (avl_rData_valid),
    .out_data  (avl_rData)
  );

endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed bench for avl_mem_responder with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_avl_mem_responder;

  localparam int ADDR_W   = 28;
  localparam int DATA_W   = 32;
  localparam int MEM_AW   = 10;
  localparam int RD_LAT   = 2;
  localparam int MAX_PEND = 2;

  logic              iCLK = 1'b0;
  logic              iRST_n = 1'b0;
  logic [ADDR_W-1:0] avl_addr = '0;
  logic              avl_read = 1'b0;
  logic              avl_write = 1'b0;
  logic [31:0]       avl_wData = '0;
  logic [3:0]        avl_byteen = '0;
  logic              avl_size = 1'b0;
  logic              avl_wait;
  logic              avl_rData_valid;
  logic [31:0]       avl_rData;
  logic              err_flag;

  always #5 iCLK = ~iCLK;

  avl_mem_responder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_AW   (MEM_AW),
    .RD_LAT   (RD_LAT),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .iCLK            (iCLK),
    .iRST_n          (iRST_n),
    .avl_addr        (avl_addr),
    .avl_read        (avl_read),
    .avl_write       (avl_write),
    .avl_wData       (avl_wData),
    .avl_byteen      (avl_byteen),
    .avl_size        (avl_size),
    .avl_wait        (avl_wait),
    .avl_rData_valid (avl_rData_valid),
    .avl_rData       (avl_rData),
    .err_flag        (err_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: a read accepted at edge n must be shown during the cycle
  // after edge n+RD_LAT-1; outstanding reads are exactly the queued entries.
  typedef struct packed {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         exp_q[$];
  logic [31:0] mdl_mem [0:(1<<MEM_AW)-1];
  logic        mdl_err = 1'b0;
  int          cyc = 0;

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      exp_q.delete();
      mdl_err = 1'b0;
    end else begin
      logic        acc, inr;
      logic [31:0] rdat;
      rd_t         e;
      acc = (avl_read || avl_write) && (exp_q.size() < MAX_PEND);
      inr = (avl_addr < ADDR_W'(1 << MEM_AW));
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
      cyc++;
      if (acc) begin
        if (avl_read && avl_write) mdl_err = 1'b1;
        if (!inr) mdl_err = 1'b1;
        rdat = inr ? mdl_mem[avl_addr[MEM_AW-1:0]] : 32'h0;
        if (avl_write && inr) begin
          for (int b = 0; b < 4; b++)
            if (avl_byteen[b]) mdl_mem[avl_addr[MEM_AW-1:0]][8*b +: 8] = avl_wData[8*b +: 8];
        end
        if (avl_read && !avl_write) begin
          e.due  = cyc + RD_LAT - 1;
          e.data = rdat;
          exp_q.push_back(e);
        end
      end
    end
  end

  logic [31:0] got_q[$];
  int          valid_cnt = 0;

  always @(negedge iCLK) begin
    if (!iRST_n) begin
      check("rst_wait",  32'(avl_wait), 32'd1);
      check("rst_valid", 32'(avl_rData_valid), 32'd0);
      check("rst_err",   32'(err_flag), 32'd0);
    end else begin
      logic ev;
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("wait",  32'(avl_wait), 32'(exp_q.size() == MAX_PEND));
      check("valid", 32'(avl_rData_valid), 32'(ev));
      if (ev) check("rdata", avl_rData, exp_q[0].data);
      check("err", 32'(err_flag), 32'(mdl_err));
      if (avl_rData_valid) begin
        got_q.push_back(avl_rData);
        valid_cnt++;
        $display("[%0d] read return data=0x%08h", cyc, avl_rData);
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input logic [3:0] be, output int acc_cyc);
    logic w;
    avl_read = rd; avl_write = wr; avl_addr = a; avl_wData = d; avl_byteen = be;
    acc_cyc = -1;
    for (int n = 0; n < 20; n++) begin
      w = avl_wait;
      @(negedge iCLK);
      if (!w) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      n_checks++;
      $display("FAIL accept_timeout: request rd=%0b wr=%0b addr=0x%0h never accepted, required acceptance within 20 cycles", rd, wr, a);
    end else begin
      $display("[%0d] accept rd=%0b wr=%0b addr=0x%0h wdata=0x%08h be=%b", acc_cyc, rd, wr, a, d, be);
    end
  endtask

  task automatic idle();
    avl_read = 1'b0;
    avl_write = 1'b0;
  endtask

  task automatic wait_valid(output logic [31:0] data, output int vcyc);
    vcyc = -1;
    data = 'x;
    for (int i = 0; i < 10; i++) begin
      if (avl_rData_valid) begin
        vcyc = cyc;
        data = avl_rData;
        break;
      end
      @(negedge iCLK);
    end
    if (vcyc < 0) begin
      n_checks++;
      $display("FAIL valid_timeout: no avl_rData_valid seen, required within 10 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc, vc, first_acc, last_acc, vcnt0;
    logic [31:0] rd;

    repeat (3) @(negedge iCLK);
    #2 iRST_n = 1'b1;
    @(negedge iCLK);

    // basic write then read
    issue(1'b0, 1'b1, 28'd4, 32'h12345678, 4'hF, acc); idle();
    issue(1'b1, 1'b0, 28'd4, 32'h0, 4'h0, acc); idle();
    wait_valid(rd, vc);
    check("basic_data", rd, 32'h12345678);
    check("basic_lat", 32'(vc + 1 - acc), 32'd2);
    check("basic_err", 32'(err_flag), 32'd0);

    // byte enables, with read immediately after write
    issue(1'b0, 1'b1, 28'd5, 32'h12345678, 4'hF, acc);
    issue(1'b0, 1'b1, 28'd5, 32'hAABBCCDD, 4'b0010, acc);
    issue(1'b1, 1'b0, 28'd5, 32'h0, 4'h0, acc); idle();
    wait_valid(rd, vc);
    check("byteen_data", rd, 32'h1234CC78);

    // backpressure: four held reads
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, ADDR_W'(i), 32'hB0B00000 + i, 4'hF, acc);
    idle();
    @(negedge iCLK);
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, ADDR_W'(i), 32'h0, 4'h0, acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
    idle();
    repeat (4) @(negedge iCLK);
    check("bp_span", 32'(last_acc - first_acc), 32'd4);
    check("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp_order", got_q[i], 32'hB0B00000 + i);

    // simultaneous read and write
    vcnt0 = valid_cnt;
    issue(1'b1, 1'b1, 28'd8, 32'hCAFEF00D, 4'hF, acc); idle();
    repeat (4) @(negedge iCLK);
    check("perr_novalid", 32'(valid_cnt - vcnt0), 32'd0);
    check("perr_err", 32'(err_flag), 32'd1);
    issue(1'b1, 1'b0, 28'd8, 32'h0, 4'h0, acc); idle();
    wait_valid(rd, vc);
    check("perr_mem", rd, 32'hCAFEF00D);
    check("perr_sticky", 32'(err_flag), 32'd1);
    repeat (2) @(negedge iCLK);

    // reset while a read is in flight
    issue(1'b1, 1'b0, 28'd4, 32'h0, 4'h0, acc); idle();
    vcnt0 = valid_cnt;
    #2 iRST_n = 1'b0;
    repeat (2) @(negedge iCLK);
    #2 iRST_n = 1'b1;
    @(negedge iCLK);
    repeat (3) @(negedge iCLK);
    check("rst_novalid", 32'(valid_cnt - vcnt0), 32'd0);
    check("rst_err_clr", 32'(err_flag), 32'd0);
    issue(1'b1, 1'b0, 28'd4, 32'h0, 4'h0, acc); idle();
    wait_valid(rd, vc);
    check("rst_mem_kept", rd, 32'h12345678);
    check("rst_lat", 32'(vc + 1 - acc), 32'd2);

    // out-of-range read
    issue(1'b1, 1'b0, ADDR_W'(1 << MEM_AW), 32'h0, 4'h0, acc); idle();
    wait_valid(rd, vc);
    check("oor_data", rd, 32'h0);
    check("oor_lat", 32'(vc + 1 - acc), 32'd2);
    check("oor_err", 32'(err_flag), 32'd1);

    repeat (3) @(negedge iCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
